// File: rtl/host_chan_rd_latency_tracker_pkg.sv
// Shared state encoding and default widths for the host-channel read latency tracker.
package host_chan_rd_latency_pkg;

  localparam int DEF_BURST_CNT_WIDTH   = 7;
  localparam int DEF_OUTSTANDING_WIDTH = 16;
  localparam int DEF_COUNTER_WIDTH     = 48;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    DRAIN = 2'd2,
    DONE  = 2'd3
  } t_rd_lat_state;

endpackage

// File: rtl/host_chan_rd_latency_tracker_sat_counter.sv
// Saturating accumulator: adds increment when en, clears on clr, sticks at all-ones.
module host_chan_rd_lat_sat_counter #(
  parameter int WIDTH = 48
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] increment,
  output logic [WIDTH-1:0] count
);

  logic [WIDTH-1:0] count_d;
  logic [WIDTH-1:0] count_q;
  logic [WIDTH:0]   sum;

  always_comb begin
    sum = {1'b0, count_q} + {1'b0, increment};
    if (clr) begin
      count_d = '0;
    end else if (en) begin
      if (sum[WIDTH]) begin
        count_d = '1;
      end else begin
        count_d = sum[WIDTH-1:0];
      end
    end else begin
      count_d = count_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      count_q <= '0;
    end else begin
      count_q <= count_d;
    end
  end

  assign count = count_q;

endmodule

// File: rtl/host_chan_rd_latency_tracker.sv
// Tracks outstanding read lines and accumulates latency/bandwidth statistics for one port.
// Optional running-maximum output enabled by defining HOST_CHAN_RD_LAT_MAX_EN.
module host_chan_rd_latency_tracker
  import host_chan_rd_latency_pkg::*;
#(
  parameter int BURST_CNT_WIDTH   = DEF_BURST_CNT_WIDTH,
  parameter int OUTSTANDING_WIDTH = DEF_OUTSTANDING_WIDTH,
  parameter int COUNTER_WIDTH     = DEF_COUNTER_WIDTH
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         en_tx_rd,
  input  logic [BURST_CNT_WIDTH-1:0]   tx_rd_cnt,
  input  logic                         en_rx_rd,
  input  logic                         start,
  input  logic                         stop,
  input  logic                         clear,
  output logic [1:0]                   state_o,
  output logic                         done,
  output logic [COUNTER_WIDTH-1:0]     rd_lines,
  output logic [COUNTER_WIDTH-1:0]     active_sum,
  output logic [COUNTER_WIDTH-1:0]     run_cycles,
  output logic [OUTSTANDING_WIDTH-1:0] outstanding,
  output logic                         err_underflow,
  output logic                         err_overflow
`ifdef HOST_CHAN_RD_LAT_MAX_EN
  ,
  output logic [OUTSTANDING_WIDTH-1:0] max_outstanding
`endif
);

  // Wide enough to hold any sum of outstanding and a burst without losing the carry.
  localparam int WIDE = (COUNTER_WIDTH > OUTSTANDING_WIDTH ? COUNTER_WIDTH : OUTSTANDING_WIDTH)
                        + BURST_CNT_WIDTH + 2;

  t_rd_lat_state state_d, state_q;
  logic [OUTSTANDING_WIDTH-1:0] outstanding_d, outstanding_q;
  logic err_underflow_d, err_underflow_q;
  logic err_overflow_d, err_overflow_q;
  logic done_d, done_q;

  logic [WIDE-1:0] out_sum;
  logic [WIDE-1:0] out_next;
  logic [WIDE-1:0] out_limit;
  logic [WIDE-1:0] cnt_limit;
  logic [WIDE-1:0] burst_wide;
  logic [WIDE-1:0] out_wide;

  logic                     cnt_clr;
  logic                     in_run;
  logic                     in_meas;
  logic [COUNTER_WIDTH-1:0] lines_inc;
  logic [COUNTER_WIDTH-1:0] active_inc;

  always_comb begin
    out_limit       = WIDE'({OUTSTANDING_WIDTH{1'b1}});
    out_sum         = WIDE'(outstanding_q) + (en_tx_rd ? WIDE'(tx_rd_cnt) : {WIDE{1'b0}});
    out_next        = out_sum - (en_rx_rd ? WIDE'(1) : {WIDE{1'b0}});
    outstanding_d   = outstanding_q;
    err_underflow_d = err_underflow_q;
    err_overflow_d  = err_overflow_q;
    if (clear) begin
      outstanding_d   = '0;
      err_underflow_d = 1'b0;
      err_overflow_d  = 1'b0;
    end else if (en_rx_rd && (out_sum == {WIDE{1'b0}})) begin
      outstanding_d   = '0;
      err_underflow_d = 1'b1;
    end else if (out_next > out_limit) begin
      outstanding_d  = '1;
      err_overflow_d = 1'b1;
    end else begin
      outstanding_d = out_next[OUTSTANDING_WIDTH-1:0];
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= IDLE;
      outstanding_q   <= '0;
      err_underflow_q <= 1'b0;
      err_overflow_q  <= 1'b0;
      done_q          <= 1'b0;
    end else begin
      state_q         <= state_d;
      outstanding_q   <= outstanding_d;
      err_underflow_q <= err_underflow_d;
      err_overflow_q  <= err_overflow_d;
      done_q          <= done_d;
    end
  end

  // start is decoded before stop, so a coincident stop in IDLE/DONE is simply lost.
  always_comb begin
    state_d = state_q;
    if (clear) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE:    if (start) state_d = RUN;   else state_d = IDLE;
        RUN:     if (stop)  state_d = DRAIN; else state_d = RUN;
        DRAIN:   if (outstanding_q == '0) state_d = DONE; else state_d = DRAIN;
        DONE:    if (start) state_d = RUN;   else state_d = DONE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_comb begin
    cnt_clr    = clear || (((state_q == IDLE) || (state_q == DONE)) && start);
    in_run     = (state_q == RUN);
    in_meas    = (state_q == RUN) || (state_q == DRAIN);
    done_d     = (state_d == DONE);
    cnt_limit  = WIDE'({COUNTER_WIDTH{1'b1}});
    burst_wide = WIDE'(tx_rd_cnt);
    out_wide   = WIDE'(outstanding_q);
    if (burst_wide > cnt_limit) begin
      lines_inc = '1;
    end else begin
      lines_inc = burst_wide[COUNTER_WIDTH-1:0];
    end
    if (out_wide > cnt_limit) begin
      active_inc = '1;
    end else begin
      active_inc = out_wide[COUNTER_WIDTH-1:0];
    end
  end

  host_chan_rd_lat_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_rd_lines (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .en        (in_run && en_tx_rd),
    .increment (lines_inc),
    .count     (rd_lines)
  );

  host_chan_rd_lat_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_active_sum (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .en        (in_meas),
    .increment (active_inc),
    .count     (active_sum)
  );

  host_chan_rd_lat_sat_counter #(.WIDTH(COUNTER_WIDTH)) u_run_cycles (
    .clk       (clk),
    .reset     (reset),
    .clr       (cnt_clr),
    .en        (in_run),
    .increment (COUNTER_WIDTH'(1)),
    .count     (run_cycles)
  );

`ifdef HOST_CHAN_RD_LAT_MAX_EN
  logic [OUTSTANDING_WIDTH-1:0] max_outstanding_d, max_outstanding_q;

  always_comb begin
    if (cnt_clr) begin
      max_outstanding_d = '0;
    end else if (in_meas && (outstanding_q > max_outstanding_q)) begin
      max_outstanding_d = outstanding_q;
    end else begin
      max_outstanding_d = max_outstanding_q;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      max_outstanding_q <= '0;
    end else begin
      max_outstanding_q <= max_outstanding_d;
    end
  end

  assign max_outstanding = max_outstanding_q;
`endif

  assign state_o       = state_q;
  assign done          = done_q;
  assign outstanding   = outstanding_q;
  assign err_underflow = err_underflow_q;
  assign err_overflow  = err_overflow_q;

endmodule

// File: tb/tb_host_chan_rd_latency_tracker.sv
// Scoreboard bench: stimulus pushes hand-computed expectations, a negedge monitor compares them.
module tb_host_chan_rd_latency_tracker;

  localparam int S_STATE = 0, S_DONE = 1, S_LINES = 2, S_ASUM = 3, S_RUNC = 4,
                 S_OUT = 5, S_UNDER = 6, S_OVER = 7, S_MAX = 8,
                 S_SM_OUT = 10, S_SM_OVER = 11, S_SM_RUNC = 12, S_SM_STATE = 13;

  typedef struct {
    string       name;
    int          sel;
    logic [63:0] exp;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic       en_tx_rd = 1'b0, en_rx_rd = 1'b0, start = 1'b0, stop = 1'b0, clear = 1'b0;
  logic [6:0] tx_rd_cnt = 7'd0;
  logic [1:0] state_o;
  logic       done, err_underflow, err_overflow;
  logic [47:0] rd_lines, active_sum, run_cycles;
  logic [15:0] outstanding;
`ifdef HOST_CHAN_RD_LAT_MAX_EN
  logic [15:0] max_outstanding;
`endif

  logic       s_en_tx = 1'b0, s_en_rx = 1'b0, s_start = 1'b0, s_stop = 1'b0, s_clear = 1'b0;
  logic [6:0] s_cnt = 7'd0;
  logic [1:0] s_state;
  logic       s_done, s_under, s_over;
  logic [3:0] s_lines, s_asum, s_runc, s_out;
`ifdef HOST_CHAN_RD_LAT_MAX_EN
  logic [3:0] s_max;
`endif

  always #5 clk = ~clk;

  host_chan_rd_latency_tracker dut (
    .clk(clk), .reset(reset), .en_tx_rd(en_tx_rd), .tx_rd_cnt(tx_rd_cnt), .en_rx_rd(en_rx_rd),
    .start(start), .stop(stop), .clear(clear), .state_o(state_o), .done(done),
    .rd_lines(rd_lines), .active_sum(active_sum), .run_cycles(run_cycles),
    .outstanding(outstanding), .err_underflow(err_underflow), .err_overflow(err_overflow)
`ifdef HOST_CHAN_RD_LAT_MAX_EN
    , .max_outstanding(max_outstanding)
`endif
  );

  host_chan_rd_latency_tracker #(.BURST_CNT_WIDTH(7), .OUTSTANDING_WIDTH(4), .COUNTER_WIDTH(4)) dut_small (
    .clk(clk), .reset(reset), .en_tx_rd(s_en_tx), .tx_rd_cnt(s_cnt), .en_rx_rd(s_en_rx),
    .start(s_start), .stop(s_stop), .clear(s_clear), .state_o(s_state), .done(s_done),
    .rd_lines(s_lines), .active_sum(s_asum), .run_cycles(s_runc),
    .outstanding(s_out), .err_underflow(s_under), .err_overflow(s_over)
`ifdef HOST_CHAN_RD_LAT_MAX_EN
    , .max_outstanding(s_max)
`endif
  );

  function automatic logic [63:0] actual(input int sel);
    case (sel)
      S_STATE:    return 64'(state_o);
      S_DONE:     return 64'(done);
      S_LINES:    return 64'(rd_lines);
      S_ASUM:     return 64'(active_sum);
      S_RUNC:     return 64'(run_cycles);
      S_OUT:      return 64'(outstanding);
      S_UNDER:    return 64'(err_underflow);
      S_OVER:     return 64'(err_overflow);
`ifdef HOST_CHAN_RD_LAT_MAX_EN
      S_MAX:      return 64'(max_outstanding);
`endif
      S_SM_OUT:   return 64'(s_out);
      S_SM_OVER:  return 64'(s_over);
      S_SM_RUNC:  return 64'(s_runc);
      S_SM_STATE: return 64'(s_state);
      default:    return 64'hFFFF_FFFF_FFFF_FFFF;
    endcase
  endfunction

  // Monitor: drains every expectation posted for the current cycle.
  always @(negedge clk) begin
    exp_t        e;
    logic [63:0] act;
    while (sb_q.size() > 0) begin
      e   = sb_q.pop_front();
      act = actual(e.sel);
      checks++;
      if (act !== e.exp) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", e.name, act, e.exp);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_val(input string nm, input int sel, input logic [63:0] v);
    exp_t e;
    e.name = nm;
    e.sel  = sel;
    e.exp  = v;
    sb_q.push_back(e);
  endtask

  task automatic expect_zero_all(input string tag);
    expect_val({tag, "_state"}, S_STATE, 64'd0);
    expect_val({tag, "_done"},  S_DONE,  64'd0);
    expect_val({tag, "_lines"}, S_LINES, 64'd0);
    expect_val({tag, "_asum"},  S_ASUM,  64'd0);
    expect_val({tag, "_runc"},  S_RUNC,  64'd0);
    expect_val({tag, "_out"},   S_OUT,   64'd0);
    expect_val({tag, "_under"}, S_UNDER, 64'd0);
    expect_val({tag, "_over"},  S_OVER,  64'd0);
  endtask

  task automatic wait_state(input string nm, input logic [1:0] st, input int max_cycles);
    int n;
    n = 0;
    while ((state_o !== st) && (n < max_cycles)) begin
      step();
      n++;
    end
    checks++;
    if (state_o !== st) begin
      errors++;
      $display("FAIL %s: wait expired after %0d cycles, state %0d expected %0d", nm, n, state_o, st);
    end
  endtask

  initial begin
    // Reset state
    step(); step();
    checks++;
    if ((state_o !== 2'd0) || (done !== 1'b0) || (outstanding !== 16'd0) ||
        (err_underflow !== 1'b0) || (err_overflow !== 1'b0)) begin
      errors++;
      $display("FAIL reset_direct: state %0d done %0d out %0d under %0d over %0d",
               state_o, done, outstanding, err_underflow, err_overflow);
    end
    expect_zero_all("reset");
    reset = 1'b0;

    stop = 1'b1; step(); stop = 1'b0;
    expect_val("stop_in_idle", S_STATE, 64'd0);

    // Saturation on the narrow instance
    s_start = 1'b1; step(); s_start = 1'b0;
    s_en_tx = 1'b1; s_cnt = 7'd8; step();
    expect_val("sat_out_first", S_SM_OUT, 64'd8);
    step(); s_en_tx = 1'b0;
    expect_val("sat_out", S_SM_OUT, 64'd15);
    expect_val("sat_over", S_SM_OVER, 64'd1);
    for (int i = 0; i < 20; i++) step();
    expect_val("sat_runc", S_SM_RUNC, 64'd15);
    expect_val("sat_state", S_SM_STATE, 64'd1);

    // Single burst: request at cycle 0, responses 10..13, stop at 20
    start = 1'b1; step(); start = 1'b0;
    expect_val("sb_run", S_STATE, 64'd1);
    for (int k = 0; k <= 21; k++) begin
      en_tx_rd  = (k == 0);
      tx_rd_cnt = (k == 0) ? 7'd4 : 7'd0;
      en_rx_rd  = (k >= 10) && (k <= 13);
      stop      = (k == 20);
      step();
      if (k == 0) begin
        expect_val("sb_out4", S_OUT, 64'd4);
        expect_val("sb_lines0", S_LINES, 64'd4);
      end
      if (k == 10) expect_val("sb_out3", S_OUT, 64'd3);
      if (k == 20) begin
        expect_val("sb_drain", S_STATE, 64'd2);
        expect_val("sb_runc_stop", S_RUNC, 64'd21);
      end
    end
    en_tx_rd = 1'b0; en_rx_rd = 1'b0; stop = 1'b0; tx_rd_cnt = 7'd0;
    wait_state("sb_wait_done", 2'd3, 50);
    expect_val("sb_done_state", S_STATE, 64'd3);
    expect_val("sb_done", S_DONE, 64'd1);
    expect_val("sb_lines", S_LINES, 64'd4);
    expect_val("sb_out0", S_OUT, 64'd0);
    expect_val("sb_asum", S_ASUM, 64'd46);
    expect_val("sb_runc", S_RUNC, 64'd21);

    // Simultaneous request/response, then drain hold from 5 outstanding
    start = 1'b1; step(); start = 1'b0;
    expect_val("restart_done_low", S_DONE, 64'd0);
    expect_val("restart_asum0", S_ASUM, 64'd0);
    en_tx_rd = 1'b1; tx_rd_cnt = 7'd3; step();
    expect_val("sim_pre", S_OUT, 64'd3);
    tx_rd_cnt = 7'd2; en_rx_rd = 1'b1; step();
    expect_val("sim_out", S_OUT, 64'd4);
    tx_rd_cnt = 7'd1; en_rx_rd = 1'b0; step();
    en_tx_rd = 1'b0; tx_rd_cnt = 7'd0;
    expect_val("dh_out5", S_OUT, 64'd5);
    stop = 1'b1; step(); stop = 1'b0;
    for (int i = 0; i < 5; i++) begin
      en_rx_rd = 1'b1; step();
      expect_val("dh_state", S_STATE, 64'd2);
      expect_val("dh_out", S_OUT, 64'(4 - i));
      expect_val("dh_runc", S_RUNC, 64'd4);
    end
    en_rx_rd = 1'b0; step();
    expect_val("dh_done", S_STATE, 64'd3);
    expect_val("dh_lines", S_LINES, 64'd6);
    expect_val("dh_asum", S_ASUM, 64'd27);

    // clear + start in DONE
    clear = 1'b1; start = 1'b1; step(); clear = 1'b0; start = 1'b0;
    expect_zero_all("clr_done");

    // Underflow
    en_rx_rd = 1'b1; step(); en_rx_rd = 1'b0;
    expect_val("uf_out", S_OUT, 64'd0);
    expect_val("uf_flag", S_UNDER, 64'd1);
    clear = 1'b1; step(); clear = 1'b0;
    expect_val("uf_clr_flag", S_UNDER, 64'd0);
    expect_val("uf_clr_state", S_STATE, 64'd0);

    // start+stop in IDLE, bursts 4+2, then reset mid-RUN
    start = 1'b1; stop = 1'b1; step(); start = 1'b0; stop = 1'b0;
    expect_val("ss_run", S_STATE, 64'd1);
    en_tx_rd = 1'b1; tx_rd_cnt = 7'd4; step();
    tx_rd_cnt = 7'd2; step();
    en_tx_rd = 1'b0; tx_rd_cnt = 7'd0; step(); step();
    expect_val("mx_out6", S_OUT, 64'd6);
`ifdef HOST_CHAN_RD_LAT_MAX_EN
    expect_val("max_out", S_MAX, 64'd6);
`endif
    reset = 1'b1; step(); reset = 1'b0;
    expect_zero_all("rst_run");
    en_rx_rd = 1'b1; step(); en_rx_rd = 1'b0;
    expect_val("late_rsp_under", S_UNDER, 64'd1);

    @(negedge clk);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
